// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
//   Parametrised universal shift register: parallel load, logical shift
//   left/right, rotate left/right, arithmetic shift right, clear and hold.
//   A saturating shift counter records how many loaded bits have left the
//   register; drained flags an empty register and drain_pulse marks the
//   single edge on which the last loaded bit was shifted out.
//
// Ports
//   clk          in   1      clock, rising edge
//   rstn         in   1      asynchronous active-low reset
//   en           in   1      synchronous enable; 0 holds all state
//   op           in   3      operation select
//   din          in   WIDTH  parallel load data
//   sin_l        in   1      serial input entering at the MSB (SHR)
//   sin_r        in   1      serial input entering at the LSB (SHL)
//   q            out  WIDTH  register contents
//   sout_l       out  1      q[WIDTH-1], the bit about to leave on SHL
//   sout_r       out  1      q[0], the bit about to leave on SHR/ASR
//   shift_cnt    out  CW     shifts since last LOAD, saturating at WIDTH
//   drained      out  1      shift_cnt == WIDTH
//   drain_pulse  out  1      one-cycle pulse when shift_cnt reaches WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int unsigned            WIDTH   = 8,
  parameter logic [WIDTH-1:0]       RST_VAL = {WIDTH{1'b0}},
  localparam int unsigned           CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained,
  output logic             drain_pulse
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             drained_r;
  logic             pulse_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             drained_nxt_s;
  logic             pulse_nxt_s;

  // Saturating increment of the shift counter: stays at WIDTH once drained.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CNT_MAX) begin
      return CNT_MAX;
    end else begin
      return c + CNT_ONE;
    end
  endfunction

  // Next-state decode for data register, counter and flags.
  always_comb begin
    q_nxt_s     = q_r;
    cnt_nxt_s   = cnt_r;
    pulse_nxt_s = 1'b0;
    if (en) begin
      case (op)
        OP_HOLD: begin
          q_nxt_s = q_r;
        end
        OP_LOAD: begin
          q_nxt_s   = din;
          cnt_nxt_s = CNT_ZERO;
        end
        OP_SHL: begin
          q_nxt_s     = {q_r[WIDTH-2:0], sin_r};
          cnt_nxt_s   = sat_inc(cnt_r);
          pulse_nxt_s = (cnt_r == CNT_LAST);
        end
        OP_SHR: begin
          q_nxt_s     = {sin_l, q_r[WIDTH-1:1]};
          cnt_nxt_s   = sat_inc(cnt_r);
          pulse_nxt_s = (cnt_r == CNT_LAST);
        end
        // Rotates lose no bits, so the count is left alone.
        OP_ROL: begin
          q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        end
        OP_ROR: begin
          q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
        end
        OP_ASR: begin
          q_nxt_s     = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          cnt_nxt_s   = sat_inc(cnt_r);
          pulse_nxt_s = (cnt_r == CNT_LAST);
        end
        OP_CLR: begin
          q_nxt_s   = RST_VAL;
          cnt_nxt_s = CNT_MAX;
        end
        default: begin
          q_nxt_s   = q_r;
          cnt_nxt_s = cnt_r;
        end
      endcase
    end else begin
      q_nxt_s     = q_r;
      cnt_nxt_s   = cnt_r;
      pulse_nxt_s = 1'b0;
    end
    // Flag is computed from the next count so it lines up with cnt_r.
    drained_nxt_s = (cnt_nxt_s == CNT_MAX);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r       <= RST_VAL;
      cnt_r     <= CNT_MAX;
      drained_r <= 1'b1;
      pulse_r   <= 1'b0;
    end else begin
      q_r       <= q_nxt_s;
      cnt_r     <= cnt_nxt_s;
      drained_r <= drained_nxt_s;
      pulse_r   <= pulse_nxt_s;
    end
  end

  assign q           = q_r;
  assign sout_l      = q_r[WIDTH-1];
  assign sout_r      = q_r[0];
  assign shift_cnt   = cnt_r;
  assign drained     = drained_r;
  assign drain_pulse = pulse_r;

endmodule
